// File: rtl/pipe_reg_e.sv
`default_nettype none
// ============================================================================
// pipe_reg_e : Y86-64 D->E pipeline register with load/use and mispredict
//              hazard control plus a saturating bubble counter.  Rev 1.0
// ============================================================================
module pipe_reg_e #(
  parameter int W     = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic [2:0]       D_stat,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       D_ifun,
  input  logic [W-1:0]     D_valC,
  input  logic [W-1:0]     d_valA,
  input  logic [W-1:0]     d_valB,
  input  logic [3:0]       d_dstE,
  input  logic [3:0]       d_dstM,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic             e_Cnd,
  output logic [2:0]       E_stat,
  output logic [3:0]       E_icode,
  output logic [3:0]       E_ifun,
  output logic [W-1:0]     E_valC,
  output logic [W-1:0]     E_valA,
  output logic [W-1:0]     E_valB,
  output logic [3:0]       E_dstE,
  output logic [3:0]       E_dstM,
  output logic [3:0]       E_srcA,
  output logic [3:0]       E_srcB,
  output logic             ld_use_stall,
  output logic             mispredict,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [2:0] C_STAT_AOK = 3'd1;
  localparam logic [3:0] C_I_NOP    = 4'h1;
  localparam logic [3:0] C_I_MRMOVQ = 4'h5;
  localparam logic [3:0] C_I_JXX    = 4'h7;
  localparam logic [3:0] C_I_POPQ   = 4'hB;
  localparam logic [3:0] C_RNONE    = 4'hF;

  logic [2:0]       stat_q,  stat_d;
  logic [3:0]       icode_q, icode_d;
  logic [3:0]       ifun_q,  ifun_d;
  logic [W-1:0]     valc_q,  valc_d;
  logic [W-1:0]     vala_q,  vala_d;
  logic [W-1:0]     valb_q,  valb_d;
  logic [3:0]       dste_q,  dste_d;
  logic [3:0]       dstm_q,  dstm_d;
  logic [3:0]       srca_q,  srca_d;
  logic [3:0]       srcb_q,  srcb_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic w_mispredict;
  logic w_ld_use;

  always_comb begin
    w_mispredict = (icode_q == C_I_JXX) && !e_Cnd;
    w_ld_use     = ((icode_q == C_I_MRMOVQ) || (icode_q == C_I_POPQ)) &&
                   (dstm_q != C_RNONE) &&
                   ((dstm_q == d_srcA) || (dstm_q == d_srcB));
  end

  always_comb begin
    stat_d  = stat_q;
    icode_d = icode_q;
    ifun_d  = ifun_q;
    valc_d  = valc_q;
    vala_d  = vala_q;
    valb_d  = valb_q;
    dste_d  = dste_q;
    dstm_d  = dstm_q;
    srca_d  = srca_q;
    srcb_d  = srcb_q;
    cnt_d   = cnt_q;
    if (hold) begin
      // frozen: keep everything
    end else if (w_mispredict || w_ld_use) begin
      stat_d  = C_STAT_AOK;
      icode_d = C_I_NOP;
      ifun_d  = 4'h0;
      valc_d  = '0;
      vala_d  = '0;
      valb_d  = '0;
      dste_d  = C_RNONE;
      dstm_d  = C_RNONE;
      srca_d  = C_RNONE;
      srcb_d  = C_RNONE;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end else begin
      stat_d  = D_stat;
      icode_d = D_icode;
      ifun_d  = D_ifun;
      valc_d  = D_valC;
      vala_d  = d_valA;
      valb_d  = d_valB;
      dste_d  = d_dstE;
      dstm_d  = d_dstM;
      srca_d  = d_srcA;
      srcb_d  = d_srcB;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q  <= C_STAT_AOK;
      icode_q <= C_I_NOP;
      ifun_q  <= 4'h0;
      valc_q  <= '0;
      vala_q  <= '0;
      valb_q  <= '0;
      dste_q  <= C_RNONE;
      dstm_q  <= C_RNONE;
      srca_q  <= C_RNONE;
      srcb_q  <= C_RNONE;
      cnt_q   <= '0;
    end else begin
      stat_q  <= stat_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      valc_q  <= valc_d;
      vala_q  <= vala_d;
      valb_q  <= valb_d;
      dste_q  <= dste_d;
      dstm_q  <= dstm_d;
      srca_q  <= srca_d;
      srcb_q  <= srcb_d;
      cnt_q   <= cnt_d;
    end
  end

  // On the wrong path the D instruction is squashed, so no stall is needed.
  assign ld_use_stall = w_ld_use && !w_mispredict;
  assign mispredict   = w_mispredict;
  assign bubble_cnt   = cnt_q;

  assign E_stat  = stat_q;
  assign E_icode = icode_q;
  assign E_ifun  = ifun_q;
  assign E_valC  = valc_q;
  assign E_valA  = vala_q;
  assign E_valB  = valb_q;
  assign E_dstE  = dste_q;
  assign E_dstM  = dstm_q;
  assign E_srcA  = srca_q;
  assign E_srcB  = srcb_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_reg_e.sv
`default_nettype none
// tb_pipe_reg_e : directed-vector bench for the D->E pipeline register.
module tb_pipe_reg_e;

  localparam int W     = 64;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n, hold, e_Cnd;
  logic [2:0] D_stat;
  logic [3:0] D_icode, D_ifun, d_dstE, d_dstM, d_srcA, d_srcB;
  logic [W-1:0] D_valC, d_valA, d_valB;
  logic [2:0] E_stat;
  logic [3:0] E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [W-1:0] E_valC, E_valA, E_valB;
  logic ld_use_stall, mispredict;
  logic [CNT_W-1:0] bubble_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_reg_e #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_valC(D_valC),
    .d_valA(d_valA), .d_valB(d_valB), .d_dstE(d_dstE), .d_dstM(d_dstM),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .e_Cnd(e_Cnd),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC),
    .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM),
    .E_srcA(E_srcA), .E_srcB(E_srcB),
    .ld_use_stall(ld_use_stall), .mispredict(mispredict), .bubble_cnt(bubble_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [63:0] valc, input logic [63:0] vala,
                       input logic [63:0] valb, input logic [3:0] dste,
                       input logic [3:0] dstm, input logic [3:0] srca,
                       input logic [3:0] srcb);
    D_stat  = 3'd1;
    D_icode = icode;
    D_ifun  = ifun;
    D_valC  = valc;
    d_valA  = vala;
    d_valB  = valb;
    d_dstE  = dste;
    d_dstM  = dstm;
    d_srcA  = srca;
    d_srcB  = srcb;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, ".stat"},  64'(E_stat),  64'h1);
    check({tag, ".icode"}, 64'(E_icode), 64'h1);
    check({tag, ".ifun"},  64'(E_ifun),  64'h0);
    check({tag, ".valA"},  E_valA,       64'h0);
    check({tag, ".dstE"},  64'(E_dstE),  64'hF);
    check({tag, ".dstM"},  64'(E_dstM),  64'hF);
    check({tag, ".srcA"},  64'(E_srcA),  64'hF);
  endtask

  initial begin
    rst_n = 1'b0;
    hold  = 1'b0;
    e_Cnd = 1'b1;
    set_d(4'h6, 4'h0, 64'h0, 64'h5, 64'h7, 4'h2, 4'hF, 4'hF, 4'hF);
    step();
    step();
    check_bubble("reset");
    check("reset.cnt", 64'(bubble_cnt), 64'h0);
    rst_n = 1'b1;
    #1;

    // Normal flow
    check("norm.stall0", 64'(ld_use_stall), 64'h0);
    check("norm.mp0",    64'(mispredict),   64'h0);
    step();
    check("norm.icode", 64'(E_icode), 64'h6);
    check("norm.valA",  E_valA,       64'h5);
    check("norm.valB",  E_valB,       64'h7);
    check("norm.dstE",  64'(E_dstE),  64'h2);
    check("norm.stall1", 64'(ld_use_stall), 64'h0);
    check("norm.mp1",   64'(mispredict),   64'h0);

    // Load/use: mrmovq into r3, consumer reads r3 as srcB
    set_d(4'h5, 4'h0, 64'h10, 64'h0, 64'h8, 4'hF, 4'h3, 4'hF, 4'h8);
    step();
    check("lu.E_icode", 64'(E_icode), 64'h5);
    set_d(4'h6, 4'h1, 64'h0, 64'hAA, 64'hBB, 4'h4, 4'hF, 4'h1, 4'h3);
    #1;
    check("lu.stall", 64'(ld_use_stall), 64'h1);
    check("lu.mp",    64'(mispredict),   64'h0);
    step();
    check_bubble("lu.bub");
    check("lu.cnt", 64'(bubble_cnt), 64'h1);
    check("lu.stall_after", 64'(ld_use_stall), 64'h0);
    step();
    check("lu.cap_icode", 64'(E_icode), 64'h6);
    check("lu.cap_valA",  E_valA,       64'hAA);
    check("lu.cap_srcB",  64'(E_srcB),  64'h3);
    check("lu.cnt2",      64'(bubble_cnt), 64'h1);

    // Mispredict
    set_d(4'h7, 4'h1, 64'h100, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF);
    step();
    e_Cnd = 1'b0;
    set_d(4'h6, 4'h0, 64'h0, 64'h1, 64'h2, 4'h5, 4'hF, 4'h6, 4'h7);
    #1;
    check("mp.flag", 64'(mispredict), 64'h1);
    step();
    check_bubble("mp.bub");
    check("mp.cnt", 64'(bubble_cnt), 64'h2);
    set_d(4'h7, 4'h2, 64'h200, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF);
    step();
    e_Cnd = 1'b1;
    set_d(4'h6, 4'h3, 64'h0, 64'h11, 64'h22, 4'h9, 4'hF, 4'hA, 4'hB);
    #1;
    check("mp.taken_flag", 64'(mispredict), 64'h0);
    step();
    check("mp.taken_icode", 64'(E_icode), 64'h6);
    check("mp.taken_valB",  E_valB,       64'h22);
    check("mp.taken_cnt",   64'(bubble_cnt), 64'h2);

    // Simultaneous: jXX in E carrying a stale dstM that matches d_srcA
    set_d(4'h7, 4'h1, 64'h300, 64'h0, 64'h0, 4'hF, 4'h3, 4'hF, 4'hF);
    step();
    e_Cnd = 1'b0;
    set_d(4'h6, 4'h0, 64'h0, 64'h1, 64'h1, 4'h2, 4'hF, 4'h3, 4'h3);
    #1;
    check("sim.stall", 64'(ld_use_stall), 64'h0);
    check("sim.mp",    64'(mispredict),   64'h1);
    step();
    check("sim.icode", 64'(E_icode), 64'h1);
    check("sim.cnt",   64'(bubble_cnt), 64'h3);
    e_Cnd = 1'b1;

    // Hold while a popq load/use is pending
    set_d(4'hB, 4'h0, 64'h0, 64'h0, 64'h0, 4'h4, 4'h4, 4'h4, 4'h4);
    step();
    set_d(4'h6, 4'h0, 64'h0, 64'h9, 64'h9, 4'h2, 4'hF, 4'h4, 4'hF);
    hold = 1'b1;
    #1;
    check("hold.stall", 64'(ld_use_stall), 64'h1);
    step();
    check("hold.icode", 64'(E_icode), 64'hB);
    check("hold.dstM",  64'(E_dstM),  64'h4);
    check("hold.cnt",   64'(bubble_cnt), 64'h3);
    hold = 1'b0;
    step();
    check("hold.rel_icode", 64'(E_icode), 64'h1);
    check("hold.rel_cnt",   64'(bubble_cnt), 64'h4);

    // 20 more bubbles must saturate the 4-bit counter at 15
    for (int i = 0; i < 20; i++) begin
      set_d(4'h7, 4'h1, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF);
      e_Cnd = 1'b1;
      step();
      e_Cnd = 1'b0;
      step();
      if (i == 10) check("sat.mid", 64'(bubble_cnt), 64'hF);
    end
    e_Cnd = 1'b1;
    check("sat.cnt", 64'(bubble_cnt), 64'hF);

    // Asynchronous reset between edges with mrmovq in E
    set_d(4'h5, 4'h0, 64'h40, 64'h0, 64'h1, 4'h3, 4'h3, 4'hF, 4'h2);
    step();
    check("ar.pre_icode", 64'(E_icode), 64'h5);
    set_d(4'h6, 4'h0, 64'h0, 64'h0, 64'h0, 4'h1, 4'hF, 4'h1, 4'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_bubble("ar");
    check("ar.cnt", 64'(bubble_cnt), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("ar.first_cap", 64'(E_icode), 64'h6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
